// File: rtl/flappy_bird_control_keyin.sv
`default_nettype none
// ============================================================================
// Module   : flappy_bird_control_keyin
// Purpose  : Avalon-MM push-button peripheral. Each active-low key input is
//            synchronized, debounced and turned into a sticky press-event bit.
//            Those bits are maskable into a level interrupt.
// Ports    : clk         - system clock, rising edge
//            reset_n     - asynchronous active-low reset
//            address     - word address (0 data, 1 reserved, 2 irq_mask,
//                          3 edge_capture)
//            chipselect  - slave select
//            write_n     - active-low write strobe
//            writedata   - write data
//            in_port     - raw key levels, 0 = pressed
//            readdata    - combinational read data, zero-extended
//            irq         - OR of (edge_capture & irq_mask)
// Revision : 1.0 - initial release
// ============================================================================
module flappy_bird_control_keyin #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] capture_q;
  logic [WIDTH-1:0] capture_d;
  logic [WIDTH-1:0] press_w;
  logic             wr_w;
  logic             unused_wdata_w;

  // Upper write-data bits are architecturally ignored.
  assign unused_wdata_w = &{1'b0, writedata};

  assign wr_w = chipselect & ~write_n;

  // Two-flop synchronizer; resets to "released" so no false press on release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: the synchronized sample must differ from the stable
  // level for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             stable_bit_d;

      always_comb begin
        cnt_d        = cnt_q;
        stable_bit_d = stable_q[i];
        if (sync2_q[i] == stable_q[i]) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d        = '0;
          stable_bit_d = sync2_q[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign stable_d[i] = stable_bit_d;
    end
  endgenerate

  // A press is a 1->0 change of the stable level, seen on the same edge the
  // stable register updates.
  assign press_w = stable_q & ~stable_d;

  always_comb begin
    mask_d    = mask_q;
    capture_d = capture_q;
    if (wr_w && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_w && (address == ADDR_EDGE)) begin
      capture_d = capture_q & ~writedata[WIDTH-1:0];
    end
    // Set is applied last so a coincident press beats a clearing write.
    capture_d = capture_d | press_w;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q  <= '1;
      mask_q    <= '0;
      capture_q <= '0;
    end else begin
      stable_q  <= stable_d;
      mask_q    <= mask_d;
      capture_q <= capture_d;
    end
  end

  // Zero-latency read path, independent of chipselect.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = ~stable_q;
      ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata[WIDTH-1:0] = capture_q;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(capture_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_flappy_bird_control_keyin.sv
`default_nettype none
// ============================================================================
// Module   : tb_flappy_bird_control_keyin
// Purpose  : Directed self-checking bench for flappy_bird_control_keyin with
//            WIDTH=4, DEBOUNCE_CYCLES=8. Inputs change and outputs are
//            sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flappy_bird_control_keyin;

  localparam int WIDTH = 4;
  localparam int DB    = 8;

  logic             clk;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int errors = 0;
  int checks = 0;

  flappy_bird_control_keyin #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    address = addr;
    #1;
    chk(tag, readdata, exp);
  endtask

  // One-cycle write spanning exactly one rising edge.
  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    tick(2);

    // Reset state
    rd_chk("rst_data", 2'd0, 32'h0);
    rd_chk("rst_mask", 2'd2, 32'h0);
    rd_chk("rst_edge", 2'd3, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(2);

    // Press bit0: capture sets exactly 10 edges after the step
    in_port = 4'hE;
    tick(9);
    rd_chk("b0_edge_at9", 2'd3, 32'h0);
    tick(1);
    rd_chk("b0_edge_at10", 2'd3, 32'h1);
    rd_chk("b0_data", 2'd0, 32'h1);
    chk("b0_irq_masked", {31'd0, irq}, 32'h0);
    wr(2'd3, 32'h1);
    rd_chk("b0_clear", 2'd3, 32'h0);
    in_port = 4'hF;
    tick(12);
    rd_chk("b0_release_noevt", 2'd3, 32'h0);
    rd_chk("b0_release_data", 2'd0, 32'h0);

    // Mask bit0, press again -> irq follows capture
    wr(2'd2, 32'h1);
    rd_chk("mask_rd", 2'd2, 32'h1);
    in_port = 4'hE;
    tick(9);
    chk("irq_at9", {31'd0, irq}, 32'h0);
    tick(1);
    chk("irq_at10", {31'd0, irq}, 32'h1);
    wr(2'd3, 32'h1);
    chk("irq_cleared", {31'd0, irq}, 32'h0);
    rd_chk("edge_cleared", 2'd3, 32'h0);
    in_port = 4'hF;
    tick(12);

    // Writes to data/reserved addresses are ignored
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'hFFFF_FFFF);
    rd_chk("rsvd_rd", 2'd1, 32'h0);
    rd_chk("mask_kept", 2'd2, 32'h1);
    rd_chk("edge_kept", 2'd3, 32'h0);
    rd_chk("data_kept", 2'd0, 32'h0);

    // Glitches on bit2: 6 cycles and DB-1 cycles, neither accepted
    in_port = 4'hB;
    tick(6);
    in_port = 4'hF;
    tick(12);
    rd_chk("glitch6_edge", 2'd3, 32'h0);
    rd_chk("glitch6_data", 2'd0, 32'h0);
    in_port = 4'hB;
    tick(DB - 1);
    in_port = 4'hF;
    tick(12);
    rd_chk("glitch7_edge", 2'd3, 32'h0);
    rd_chk("glitch7_data", 2'd0, 32'h0);

    // Press bit1 with a clearing write in the acceptance cycle: set wins
    in_port = 4'hD;
    tick(9);
    wr(2'd3, 32'h2);
    rd_chk("set_wins", 2'd3, 32'h2);
    chk("irq_mask_and", {31'd0, irq}, 32'h0);
    wr(2'd3, 32'h1);
    rd_chk("partial_clear", 2'd3, 32'h2);
    wr(2'd3, 32'hF);
    rd_chk("full_clear", 2'd3, 32'h0);
    in_port = 4'hF;
    tick(12);

    // Reset mid-debounce on bit3 (counter at 5), key held through reset
    in_port = 4'h7;
    tick(7);
    reset_n = 1'b0;
    tick(2);
    rd_chk("mid_rst_data", 2'd0, 32'h0);
    rd_chk("mid_rst_mask", 2'd2, 32'h0);
    reset_n = 1'b1;
    tick(9);
    rd_chk("b3_edge_at9", 2'd3, 32'h0);
    tick(1);
    rd_chk("b3_edge_at10", 2'd3, 32'h8);
    rd_chk("b3_data", 2'd0, 32'h8);
    chk("b3_irq_masked", {31'd0, irq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flappy_bird_control_keyin.md
FLAPPY_BIRD_CONTROL_KEYIN -- requirements
Module: flappy_bird_control_keyin

Interface
REQ-001 Parameter WIDTH, default 4: number of push-button inputs.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: clk cycles of stable input required to accept a level (10 ms at 50 MHz); legal range 2 to 2^20.
REQ-003 clk  input  1  system clock, all state rising-edge triggered.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 in_port  input  WIDTH  raw asynchronous key levels, active-low (0 = pressed).
REQ-010 readdata  output  32  read data, zero-extended.
REQ-011 irq  output  1  level interrupt request, active-high.

Function
REQ-012 Each in_port bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Each bit SHALL have an independent debounce counter of ceil(log2(DEBOUNCE_CYCLES)) bits and a stable-level register.
REQ-014 Debounce: synchronized sample equal to stable level -> counter cleared to 0.
REQ-015 Debounce: sample differs and counter < DEBOUNCE_CYCLES-1 -> counter increments by 1.
REQ-016 Debounce: sample differs and counter == DEBOUNCE_CYCLES-1 -> stable level takes sample, counter cleared; counter never wraps.
REQ-017 A press event for bit i SHALL be a 1->0 transition of stable level i; 0->1 transitions SHALL generate no event.
REQ-018 Register map (word address): 0 data (R), 1 reserved (reads 0, writes ignored), 2 irq_mask (R/W, WIDTH bits), 3 edge_capture (R, write-1-to-clear).
REQ-019 Data read SHALL return the inverted stable levels (1 = pressed) in bits [WIDTH-1:0].
REQ-020 Reads SHALL have zero wait states and zero read latency: readdata is combinational from address and registers; chipselect not required for readdata validity.
REQ-021 Write to address 2 (chipselect=1, write_n=0) SHALL load irq_mask from writedata[WIDTH-1:0] on the next clk edge.
REQ-022 Write to address 3 SHALL clear each edge_capture bit whose writedata bit is 1; bits with writedata 0 unchanged.
REQ-023 A press event SHALL set the corresponding edge_capture bit on the same clk edge the stable level changes; bit holds until cleared.
REQ-024 Press event and clearing write to the same bit in the same cycle: set SHALL win (bit reads 1 afterwards).
REQ-025 Writes to addresses 0 and 1 SHALL have no effect.
REQ-026 irq SHALL equal OR-reduction of (edge_capture AND irq_mask), registered-input combinational, no extra latency.
REQ-027 Raw press to edge_capture set latency SHALL be exactly 2 (sync) + DEBOUNCE_CYCLES clk cycles for a clean step input.
REQ-028 Input glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no stable change and no event.

Reset
REQ-029 reset_n low SHALL asynchronously set synchronizer flops and stable levels to all ones (released), counters to 0, irq_mask to 0, edge_capture to 0; hence irq=0, data reads 0.
REQ-030 Reset asserted mid-debounce SHALL discard the partial count; after release a held key requires a full new DEBOUNCE_CYCLES interval and then generates a press event.
REQ-031 Reset deassertion is assumed synchronized externally; no operation requirement in the first cycle after release beyond holding reset values.

Verification (DEBOUNCE_CYCLES=8, WIDTH=4)
REQ-032 Reset, in_port=4'hF, read addr 0/2/3 -> 0,0,0; irq=0.
REQ-033 in_port bit0 -> 0 at cycle T, held -> edge_capture=4'h1 at T+10, data reads 4'h1; irq stays 0 with mask 0.
REQ-034 Write mask 4'h1, press bit0 -> irq=1 when capture sets; write 4'h1 to addr 3 -> capture 0, irq 0 next cycle.
REQ-035 bit2 low for 6 cycles then high -> no capture, data bit2 stays 0; release after accepted press -> no new capture.
REQ-036 Clear-write to addr 3 with data 4'h2 in the exact cycle bit1 press is accepted -> edge_capture bit1 reads 1.
REQ-037 Assert reset_n with bit3 counter at 5, key held low, release reset -> capture bit3 sets exactly 10 cycles after release.
